// File: rtl/axi_slave_mem.sv
// axi_slave_mem: AXI4 slave backed by an on-chip word array.
// Write and read channels run as independent FSMs sharing one memory; all outputs registered.
module axi_slave_mem #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned MEM_DEPTH  = 256
) (
  input  logic                    aclk,
  input  logic                    arst_n,
  // write address
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  // write data
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  // write response
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  // read address
  input  logic [ID_WIDTH-1:0]     arid,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  input  logic                    arvalid,
  output logic                    arready,
  // read data
  output logic [ID_WIDTH-1:0]     rid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int unsigned StrbW = DATA_WIDTH / 8;
  localparam int unsigned Shift = $clog2(StrbW);
  localparam int unsigned IdxW  = ADDR_WIDTH - Shift;
  localparam int unsigned MemAw = $clog2(MEM_DEPTH);

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;
  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstWrap  = 2'b10;

  typedef enum logic [1:0] {StWIdle, StWData, StWResp} w_state_e;
  typedef enum logic {StRIdle, StRData} r_state_e;

  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

  // Illegal burst type or WRAP length: run as INCR but flag SLVERR.
  function automatic logic burst_err(input logic [1:0] burst, input logic [7:0] len);
    return (burst == 2'b11) || ((burst == BurstWrap) && !wrap_len_ok(len));
  endfunction

  function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] idx,
                                               input logic [7:0] len, input logic [1:0] burst);
    logic [IdxW-1:0] mask;
    mask = IdxW'(len);
    if (burst == BurstFixed) return idx;
    // len+1 is a power of two here, so len doubles as the in-window offset mask
    if ((burst == BurstWrap) && wrap_len_ok(len)) return (idx & ~mask) | ((idx + 1'b1) & mask);
    return idx + 1'b1;
  endfunction

  function automatic logic idx_in_range(input logic [IdxW-1:0] idx);
    return idx < IdxW'(MEM_DEPTH);
  endfunction

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Size and sub-word address bits carry no information for a full-width word store.
  logic unused_inputs;
  assign unused_inputs = ^{awsize, arsize, awaddr[Shift-1:0], araddr[Shift-1:0]};

  // ---------------- write channel ----------------
  w_state_e              w_state_q, w_state_d;
  logic [ID_WIDTH-1:0]   bid_q, bid_d;
  logic [IdxW-1:0]       w_idx_q, w_idx_d;
  logic [7:0]            w_len_q, w_len_d, w_beat_q, w_beat_d;
  logic [1:0]            w_burst_q, w_burst_d;
  logic                  w_err_q, w_err_d;
  logic                  awready_q, wready_q, bvalid_q;
  logic [1:0]            bresp_q;
  logic                  mem_we;

  // Write next-state: latch AW, accept beats, report error flag on B.
  always_comb begin
    w_state_d = w_state_q;
    bid_d     = bid_q;
    w_idx_d   = w_idx_q;
    w_len_d   = w_len_q;
    w_burst_d = w_burst_q;
    w_beat_d  = w_beat_q;
    w_err_d   = w_err_q;
    mem_we    = 1'b0;
    unique case (w_state_q)
      StWIdle: begin
        if (awvalid && awready_q) begin
          bid_d     = awid;
          w_idx_d   = awaddr[ADDR_WIDTH-1:Shift];
          w_len_d   = awlen;
          w_burst_d = awburst;
          w_beat_d  = 8'd0;
          w_err_d   = burst_err(awburst, awlen);
          w_state_d = StWData;
        end
      end
      StWData: begin
        if (wvalid && wready_q) begin
          mem_we = idx_in_range(w_idx_q);
          if (!idx_in_range(w_idx_q) || (wlast != (w_beat_q == w_len_q))) w_err_d = 1'b1;
          w_beat_d = w_beat_q + 8'd1;
          w_idx_d  = next_idx(w_idx_q, w_len_q, w_burst_q);
          if (wlast) w_state_d = StWResp;
        end
      end
      StWResp: begin
        if (bready && bvalid_q) w_state_d = StWIdle;
      end
      default: w_state_d = StWIdle;
    endcase
  end

  // Write state and registered AW/W/B outputs.
  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      w_state_q <= StWIdle;
      bid_q     <= '0;
      w_idx_q   <= '0;
      w_len_q   <= '0;
      w_burst_q <= '0;
      w_beat_q  <= '0;
      w_err_q   <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RespOkay;
    end else begin
      w_state_q <= w_state_d;
      bid_q     <= bid_d;
      w_idx_q   <= w_idx_d;
      w_len_q   <= w_len_d;
      w_burst_q <= w_burst_d;
      w_beat_q  <= w_beat_d;
      w_err_q   <= w_err_d;
      awready_q <= (w_state_d == StWIdle);
      wready_q  <= (w_state_d == StWData);
      bvalid_q  <= (w_state_d == StWResp);
      bresp_q   <= ((w_state_d == StWResp) && w_err_d) ? RespSlverr : RespOkay;
    end
  end

  // Byte-lane memory write; storage is deliberately not reset.
  always_ff @(posedge aclk) begin
    if (mem_we) begin
      for (int b = 0; b < StrbW; b++) begin
        if (wstrb[b]) mem[w_idx_q[MemAw-1:0]][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  r_state_e              r_state_q, r_state_d;
  logic [ID_WIDTH-1:0]   rid_q, rid_d;
  logic [IdxW-1:0]       r_idx_q, r_idx_d, rd_idx;
  logic [7:0]            r_len_q, r_len_d, r_beat_q, r_beat_d;
  logic [1:0]            r_burst_q, r_burst_d;
  logic                  r_berr_q, r_berr_d;
  logic                  arready_q, rvalid_q, rlast_q, rlast_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  rd_load;

  // Read next-state: latch AR, preload beat 0, load next beat on each handshake.
  always_comb begin
    r_state_d = r_state_q;
    rid_d     = rid_q;
    r_idx_d   = r_idx_q;
    r_len_d   = r_len_q;
    r_burst_d = r_burst_q;
    r_beat_d  = r_beat_q;
    r_berr_d  = r_berr_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rlast_d   = rlast_q;
    rd_idx    = r_idx_q;
    rd_load   = 1'b0;
    unique case (r_state_q)
      StRIdle: begin
        if (arvalid && arready_q) begin
          rid_d     = arid;
          r_len_d   = arlen;
          r_burst_d = arburst;
          r_berr_d  = burst_err(arburst, arlen);
          r_beat_d  = 8'd0;
          rd_idx    = araddr[ADDR_WIDTH-1:Shift];
          rd_load   = 1'b1;
          rlast_d   = (arlen == 8'd0);
          r_state_d = StRData;
        end
      end
      StRData: begin
        if (rready && rvalid_q) begin
          if (rlast_q) begin
            rlast_d   = 1'b0;
            r_state_d = StRIdle;
          end else begin
            rd_idx   = next_idx(r_idx_q, r_len_q, r_burst_q);
            rd_load  = 1'b1;
            r_beat_d = r_beat_q + 8'd1;
            rlast_d  = (r_beat_d == r_len_q);
          end
        end
      end
      default: r_state_d = StRIdle;
    endcase
    // Array read sees pre-write contents, giving read-before-write on a same-cycle collision.
    if (rd_load) begin
      r_idx_d = rd_idx;
      rdata_d = idx_in_range(rd_idx) ? mem[rd_idx[MemAw-1:0]] : '0;
      rresp_d = (r_berr_d || !idx_in_range(rd_idx)) ? RespSlverr : RespOkay;
    end
  end

  // Read state and registered AR/R outputs.
  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      r_state_q <= StRIdle;
      rid_q     <= '0;
      r_idx_q   <= '0;
      r_len_q   <= '0;
      r_burst_q <= '0;
      r_beat_q  <= '0;
      r_berr_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RespOkay;
      rlast_q   <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      rid_q     <= rid_d;
      r_idx_q   <= r_idx_d;
      r_len_q   <= r_len_d;
      r_burst_q <= r_burst_d;
      r_beat_q  <= r_beat_d;
      r_berr_q  <= r_berr_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rlast_q   <= rlast_d;
      arready_q <= (r_state_d == StRIdle);
      rvalid_q  <= (r_state_d == StRData);
    end
  end

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;
  assign bid     = bid_q;
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign rlast   = rlast_q;
  assign rid     = rid_q;

endmodule

// File: doc/axi_slave_mem.md
# axi_slave_mem

- Synthesizable AXI4 memory slave with on-chip word-addressed storage.
- Responds to the AXI master BFM: accepts write bursts and returns a B response; accepts read bursts and returns R data.
- Gives the VIP environment a real DUT in place of the slave BFM, so the master BFM, monitor and coverage run against RTL.
- Write and read channels are independent FSMs sharing one memory array.

## Interface

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, data bus width; must be 32 or 64.
- ID_WIDTH, 4, transaction ID width.
- MEM_DEPTH, 256, number of DATA_WIDTH words.

Ports:
- aclk  in  1  clock, all logic on rising edge.
- arst_n  in  1  asynchronous active-low reset.
- awid/awaddr/awlen/awsize/awburst  in  ID_WIDTH/ADDR_WIDTH/8/3/2  write address channel.
- awvalid in 1, awready out 1  AW handshake.
- wdata/wstrb/wlast  in  DATA_WIDTH/DATA_WIDTH/8/1  write data.
- wvalid in 1, wready out 1  W handshake.
- bid/bresp  out  ID_WIDTH/2  write response.
- bvalid out 1, bready in 1  B handshake.
- arid/araddr/arlen/arsize/arburst  in  same widths as AW  read address channel.
- arvalid in 1, arready out 1  AR handshake.
- rid/rdata/rresp/rlast  out  ID_WIDTH/DATA_WIDTH/2/1  read data.
- rvalid out 1, rready in 1  R handshake.

## Operation

- Word index = addr >> log2(DATA_WIDTH/8); low address bits ignored.
- awsize/arsize ignored: every beat is full width, byte lanes qualified by wstrb only.
- Burst address update per beat:
  - FIXED (00): index constant.
  - INCR (01): index+1.
  - WRAP (10): wraps within a (len+1)-word aligned window; legal for len in {1,3,7,15}.
  - Any other len with WRAP, or burst=11: treated as INCR, response SLVERR.
- Index >= MEM_DEPTH is out of range:
  - write beat suppressed;
  - read beat returns rdata=0;
  - resp SLVERR (2'b10).
- OKAY = 2'b00.
- Write FSM (W_IDLE, W_DATA, W_RESP):
  - W_IDLE: awready=1. On AW handshake, latch id/addr/len/burst, clear beat counter and error flag → W_DATA.
  - W_DATA: wready=1. Each handshake writes bytes with wstrb set, counter+1.
    - wlast on beat != awlen, or beat awlen without wlast: set error flag, keep accepting until wlast.
    - On wlast handshake → W_RESP.
  - W_RESP: bvalid=1, bid=latched id, bresp=SLVERR if error flag else OKAY. On bready → W_IDLE.
- Read FSM (R_IDLE, R_DATA):
  - R_IDLE: arready=1. On AR handshake, latch fields → R_DATA.
  - R_DATA: rvalid=1, rid=latched id, rlast=(beat==arlen).
    - rdata/rresp/rlast held stable while rvalid && !rready.
    - On handshake: advance address and load next beat. After the last beat → R_IDLE.
- Same-cycle write and read of one word: read data reflects the memory value before that cycle's write.
- Memory contents are not reset.

## Timing

- All outputs registered.
- While arst_n=0 (asynchronous), all of these are 0: awready, wready, bvalid, arready, rvalid, rlast, bresp, rresp, bid, rid, rdata. Both FSMs are forced to idle.
- After arst_n deasserts: awready=1 and arready=1 on the first rising aclk.
- Write latency:
  - AW handshake at edge N → wready=1 from N+1.
  - wlast handshake at edge M → bvalid=1 from M+1.
  - B handshake at edge K → awready=1 from K+1.
- Read latency:
  - AR handshake at edge N → rvalid=1 with beat 0 from N+1.
  - With rready held high: one beat per cycle, no bubbles.
  - Last R handshake at K → arready=1 from K+1.
- Single outstanding transaction per direction: awready=0 outside W_IDLE, arready=0 outside R_IDLE.
- Reset asserted mid-burst aborts the burst with no response. Words already written remain.

## Test plan

- Write INCR awaddr=0x10, awlen=3, data 0xA0..0xA3, wstrb=0xF → bresp=OKAY, bid echoed. Read INCR araddr=0x10, arlen=3 → 0xA0..0xA3, rlast only on beat 3.
- WRAP read araddr=0x18, arlen=3 after filling words 4..7 with 4,5,6,7 → beats return 6,7,4,5.
- wstrb=0x3 write of 0xFFFFFFFF over 0x12345678 → readback 0x1234FFFF. FIXED write burst len=2 → only the last beat's data remains.
- Out-of-range: awaddr=MEM_DEPTH*4 → bresp=SLVERR, memory unchanged. Read at the same address → rdata=0, rresp=SLVERR on every beat.
- Backpressure: rready toggled 1/0 each cycle and bready held low 5 cycles → rdata stable while stalled, awready stays 0 until the B handshake. wlast early at beat 1 of len=3 → bresp=SLVERR.
- arst_n pulsed low mid read burst → rvalid=0 immediately. arready=1 on the first edge after release; the next burst completes correctly.
